// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the fetch pipe: instruction codes, status codes,
// fetch FSM states, the registered payload layout and the instruction length rule.
package y86_pkg;

    localparam int unsigned BYTES_W = 80;
    localparam int unsigned VALC_W  = 64;
    localparam int unsigned NIB_W   = 4;

    localparam logic [NIB_W-1:0] I_HALT   = 4'h0;
    localparam logic [NIB_W-1:0] I_NOP    = 4'h1;
    localparam logic [NIB_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [NIB_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [NIB_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [NIB_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [NIB_W-1:0] I_OPQ    = 4'h6;
    localparam logic [NIB_W-1:0] I_JXX    = 4'h7;
    localparam logic [NIB_W-1:0] I_CALL   = 4'h8;
    localparam logic [NIB_W-1:0] I_RET    = 4'h9;
    localparam logic [NIB_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [NIB_W-1:0] I_POPQ   = 4'hB;
    localparam logic [NIB_W-1:0] R_NONE   = 4'hF;

    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_RET = 2'd1,
        ST_STOPPED  = 2'd2
    } fetch_state_e;

    // Address-independent part of a fetched instruction
    typedef struct packed {
        logic [NIB_W-1:0]  icode;
        logic [NIB_W-1:0]  ifun;
        logic [NIB_W-1:0]  ra;
        logic [NIB_W-1:0]  rb;
        logic [VALC_W-1:0] valc;
        stat_e             stat;
    } fetch_fields_t;

    localparam fetch_fields_t FIELDS_RST = '{
        icode: 4'h0, ifun: 4'h0, ra: R_NONE, rb: R_NONE, valc: 64'h0, stat: STAT_AOK
    };

    // Unknown icodes are one byte long so the PC still advances past them
    function automatic logic [NIB_W-1:0] instr_len(input logic [NIB_W-1:0] icode);
        logic [NIB_W-1:0] len;
        case (icode)
            I_HALT, I_NOP, I_RET:                len = 4'd1;
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:    len = 4'd2;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:        len = 4'd10;
            I_JXX, I_CALL:                       len = 4'd9;
            default:                             len = 4'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fetch_pipe_if.sv
// Fetch-stage bus: instruction memory window, redirect request and the
// decoded-instruction output with its valid/ready handshake.
interface fetch_pipe_if
    import y86_pkg::*;
#(
    parameter int unsigned ADDR_W = 64
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [BYTES_W-1:0] imem_bytes;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               f_valid;
    logic               f_ready;
    logic [NIB_W-1:0]   f_icode;
    logic [NIB_W-1:0]   f_ifun;
    logic [NIB_W-1:0]   f_rA;
    logic [NIB_W-1:0]   f_rB;
    logic [VALC_W-1:0]  f_valC;
    logic [ADDR_W-1:0]  f_valP;
    logic [ADDR_W-1:0]  f_predPC;
    logic [2:0]         f_stat;

    modport master (
        output imem_addr, f_valid, f_icode, f_ifun, f_rA, f_rB,
               f_valC, f_valP, f_predPC, f_stat,
        input  imem_bytes, redirect_valid, redirect_pc, f_ready
    );

    modport slave (
        input  imem_addr, f_valid, f_icode, f_ifun, f_rA, f_rB,
               f_valC, f_valP, f_predPC, f_stat,
        output imem_bytes, redirect_valid, redirect_pc, f_ready
    );
endinterface

// File: rtl/fetch_predecode.sv
// Combinational decode of the ten-byte window at the PC: fields, constant,
// next sequential PC, predicted PC and fetch status.
module fetch_predecode
    import y86_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned IMEM_BYTES = 128
) (
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [BYTES_W-1:0] bytes_i,
    output fetch_fields_t      fields_o,
    output logic [ADDR_W-1:0]  valp_o,
    output logic [ADDR_W-1:0]  predpc_o
);
    localparam int unsigned EXT_W = ADDR_W + 1;

    logic [NIB_W-1:0] icode;
    logic [NIB_W-1:0] len;
    logic [EXT_W-1:0] end_addr;
    logic             adr_err;

    always_comb begin
        icode    = bytes_i[7:4];
        len      = instr_len(icode);
        fields_o = FIELDS_RST;
        fields_o.icode = icode;
        fields_o.ifun  = bytes_i[3:0];

        case (icode)
            I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                fields_o.ra = bytes_i[15:12];
                fields_o.rb = bytes_i[11:8];
            end
            default: ;
        endcase

        case (icode)
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: fields_o.valc = bytes_i[79:16];
            I_JXX, I_CALL:                fields_o.valc = bytes_i[71:8];
            default:                      fields_o.valc = '0;
        endcase

        valp_o   = pc_i + ADDR_W'(len);
        predpc_o = (icode == I_JXX || icode == I_CALL) ? ADDR_W'(fields_o.valc) : valp_o;

        // One extra bit keeps the end-of-instruction address from wrapping
        end_addr = {1'b0, pc_i} + EXT_W'(len);
        adr_err  = ({1'b0, pc_i} >= EXT_W'(IMEM_BYTES)) || (end_addr > EXT_W'(IMEM_BYTES));

        if (adr_err)               fields_o.stat = STAT_ADR;
        else if (icode > I_POPQ)   fields_o.stat = STAT_INS;
        else if (icode == I_HALT)  fields_o.stat = STAT_HLT;
        else                       fields_o.stat = STAT_AOK;
    end

endmodule

// File: rtl/fetch_pipe.sv
// Y86 fetch stage: PC register, RUN/WAIT_RET/STOPPED control and the
// registered decoded-instruction output with valid/ready handshake.
module fetch_pipe
    import y86_pkg::*;
#(
    parameter int unsigned       ADDR_W     = 64,
    parameter int unsigned       IMEM_BYTES = 128,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input logic          clock,
    input logic          reset,
    fetch_pipe_if.master bus
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    fetch_fields_t     fields_q, fields_d;
    logic [ADDR_W-1:0] valp_q, valp_d;
    logic [ADDR_W-1:0] predpc_q, predpc_d;

    fetch_fields_t     dec_fields;
    logic [ADDR_W-1:0] dec_valp;
    logic [ADDR_W-1:0] dec_predpc;
    logic              capture;
    logic              accept;

    fetch_predecode #(
        .ADDR_W     (ADDR_W),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_predecode (
        .pc_i     (pc_q),
        .bytes_i  (bus.imem_bytes),
        .fields_o (dec_fields),
        .valp_o   (dec_valp),
        .predpc_o (dec_predpc)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            fields_q <= FIELDS_RST;
            valp_q   <= RESET_PC;
            predpc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            fields_q <= fields_d;
            valp_q   <= valp_d;
            predpc_q <= predpc_d;
        end
    end

    // Redirect beats capture; a stalled output register simply holds
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        fields_d = fields_q;
        valp_d   = valp_q;
        predpc_d = predpc_q;
        capture  = (state_q == ST_RUN) && (!valid_q || bus.f_ready);
        accept   = valid_q && bus.f_ready;

        if (bus.redirect_valid) begin
            pc_d    = bus.redirect_pc;
            valid_d = 1'b0;
            state_d = ST_RUN;
        end else if (capture) begin
            fields_d = dec_fields;
            valp_d   = dec_valp;
            predpc_d = dec_predpc;
            valid_d  = 1'b1;
            pc_d     = dec_predpc;
            if (dec_fields.stat != STAT_AOK)
                state_d = ST_STOPPED;
            else if (dec_fields.icode == I_RET)
                state_d = ST_WAIT_RET;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.f_valid   = valid_q;
    assign bus.f_icode   = fields_q.icode;
    assign bus.f_ifun    = fields_q.ifun;
    assign bus.f_rA      = fields_q.ra;
    assign bus.f_rB      = fields_q.rb;
    assign bus.f_valC    = fields_q.valc;
    assign bus.f_valP    = valp_q;
    assign bus.f_predPC  = predpc_q;
    assign bus.f_stat    = fields_q.stat;

endmodule

// File: tb/tb_fetch_pipe.sv
// Self-checking bench for fetch_pipe: directed scenarios plus randomized
// programs checked against a byte-level reference decoder.
module tb_fetch_pipe;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned IMEM   = 128;
    localparam int LEN_TAB [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};

    typedef struct packed {
        logic        v;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] predpc;
        logic [2:0]  stat;
    } obs_t;

    localparam obs_t RST_OBS = '{v: 1'b0, icode: 4'h0, ifun: 4'h0, ra: 4'hF, rb: 4'hF,
                                 valc: 64'h0, valp: 64'h0, predpc: 64'h0, stat: 3'd1};

    logic clock;
    logic reset;
    logic [7:0] mem [0:IMEM-1];
    int n_checks;
    int n_pass;

    fetch_pipe_if #(.ADDR_W(ADDR_W)) bus ();

    fetch_pipe #(
        .ADDR_W     (ADDR_W),
        .IMEM_BYTES (IMEM),
        .RESET_PC   (64'h0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: bytes outside the array read as zero
    always_comb begin
        bus.imem_bytes = '0;
        for (int i = 0; i < 10; i++)
            if (bus.imem_addr < 64'(IMEM) && bus.imem_addr + 64'(i) < 64'(IMEM))
                bus.imem_bytes[8*i +: 8] = mem[7'(bus.imem_addr + 64'(i))];
    end

    function automatic obs_t observe();
        return '{v: bus.f_valid, icode: bus.f_icode, ifun: bus.f_ifun, ra: bus.f_rA, rb: bus.f_rB,
                 valc: bus.f_valC, valp: bus.f_valP, predpc: bus.f_predPC, stat: bus.f_stat};
    endfunction

    function automatic obs_t mk(logic [3:0] icode, logic [3:0] ifun, logic [3:0] ra, logic [3:0] rb,
                                logic [63:0] valc, logic [63:0] valp, logic [63:0] predpc, logic [2:0] stat);
        return '{v: 1'b1, icode: icode, ifun: ifun, ra: ra, rb: rb,
                 valc: valc, valp: valp, predpc: predpc, stat: stat};
    endfunction

    function automatic logic [7:0] rd(logic [63:0] a);
        return (a < 64'(IMEM)) ? mem[a[6:0]] : 8'h00;
    endfunction

    // Reference decode straight from the instruction-set rules
    function automatic obs_t ref_decode(logic [63:0] pc);
        obs_t e;
        logic [7:0] b0;
        int len;
        b0 = rd(pc);
        e = RST_OBS;
        e.v = 1'b1;
        e.icode = b0[7:4];
        e.ifun = b0[3:0];
        len = LEN_TAB[b0[7:4]];
        if ((e.icode >= 2 && e.icode <= 6) || e.icode == 4'hA || e.icode == 4'hB) begin
            e.ra = rd(pc + 1) >> 4;
            e.rb = rd(pc + 1) & 8'h0F;
        end
        for (int j = 0; j < 8; j++) begin
            if (e.icode >= 3 && e.icode <= 5) e.valc[8*j +: 8] = rd(pc + 64'(2 + j));
            if (e.icode == 7 || e.icode == 8) e.valc[8*j +: 8] = rd(pc + 64'(1 + j));
        end
        e.valp = pc + 64'(len);
        e.predpc = (e.icode == 7 || e.icode == 8) ? e.valc : e.valp;
        if (pc >= 64'(IMEM) || pc + 64'(len) > 64'(IMEM)) e.stat = 3'd3;
        else if (e.icode > 4'hB)                          e.stat = 3'd4;
        else if (e.icode == 4'h0)                         e.stat = 3'd2;
        else                                              e.stat = 3'd1;
        return e;
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < IMEM; a++) mem[a] = 8'h00;
    endtask

    task automatic do_reset();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.f_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic redirect_to(logic [63:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = target;
        @(negedge clock);
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        clear_mem();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.f_ready = 1'b0;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({observe(), bus.imem_addr} !== {RST_OBS, 64'h0})
            $display("FAIL reset_values got=%h/%h want=%h/0", observe(), bus.imem_addr, RST_OBS);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h1, 3'd2))
            $display("FAIL halt_at_zero got=%h", observe());
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({observe(), bus.imem_addr} !== {RST_OBS, 64'h0})
            $display("FAIL async_reset got=%h/%h want=%h/0", observe(), bus.imem_addr, RST_OBS);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_irmovq();
        logic [7:0] b [10] = '{8'h30, 8'hF3, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = b[i];
        do_reset();
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h3, 4'h0, 4'hF, 4'h3, 64'h0A, 64'd10, 64'd10, 3'd1))
            $display("FAIL irmovq_fields got=%h", observe());
        else n_pass++;
        n_checks++;
        if (bus.imem_addr !== 64'd10) $display("FAIL irmovq_next_pc got=%h want=a", bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_jump_stall();
        obs_t ej;
        clear_mem();
        mem[0] = 8'h70;
        mem[1] = 8'h20;
        mem[8'h20] = 8'h10;
        do_reset();
        @(negedge clock);
        ej = mk(4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'd9, 64'h20, 3'd1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({observe(), bus.imem_addr} !== {ej, 64'h20})
                $display("FAIL jump_hold%0d got=%h/%h want=%h/20", k, observe(), bus.imem_addr, ej);
            else n_pass++;
            if (k < 3) @(negedge clock);
        end
        bus.f_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h21, 64'h21, 3'd1))
            $display("FAIL jump_target_fetch got=%h", observe());
        else n_pass++;
    endtask

    task automatic test_ret();
        clear_mem();
        mem[5] = 8'h90;
        mem[6] = 8'h10;
        mem[8'h40] = 8'h60;
        mem[8'h41] = 8'h12;
        do_reset();
        redirect_to(64'h5);
        bus.f_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h6, 64'h6, 3'd1))
            $display("FAIL ret_fields got=%h", observe());
        else n_pass++;
        repeat (3) begin
            @(negedge clock);
            n_checks++;
            if ({bus.f_valid, bus.imem_addr} !== {1'b0, 64'h6})
                $display("FAIL ret_wait got=%b/%h want=0/6", bus.f_valid, bus.imem_addr);
            else n_pass++;
        end
        redirect_to(64'h40);
        n_checks++;
        if ({bus.f_valid, bus.imem_addr} !== {1'b0, 64'h40})
            $display("FAIL ret_redirect got=%b/%h want=0/40", bus.f_valid, bus.imem_addr);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h42, 64'h42, 3'd1))
            $display("FAIL ret_resume got=%h", observe());
        else n_pass++;
    endtask

    task automatic test_adr();
        logic [7:0] b [10] = '{8'h30, 8'hF1, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        clear_mem();
        for (int i = 0; i < 10; i++) mem[118 + i] = b[i];
        do_reset();
        redirect_to(64'd118);
        bus.f_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h3, 4'h0, 4'hF, 4'h1, 64'h8877665544332211, 64'd128, 64'd128, 3'd1))
            $display("FAIL adr_edge_ok got=%h", observe());
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'd129, 64'd129, 3'd3))
            $display("FAIL adr_beyond_mem got=%h", observe());
        else n_pass++;
        for (int i = 0; i < 8; i++) mem[120 + i] = (i == 0) ? 8'h30 : (i == 1) ? 8'hF2 : 8'(8'hA1 + i - 2);
        redirect_to(64'd120);
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h3, 4'h0, 4'hF, 4'h2, 64'h0000A6A5A4A3A2A1, 64'd130, 64'd130, 3'd3))
            $display("FAIL adr_straddle got=%h", observe());
        else n_pass++;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({bus.f_valid, bus.imem_addr} !== {1'b0, 64'd130})
            $display("FAIL adr_stopped got=%b/%h want=0/82", bus.f_valid, bus.imem_addr);
        else n_pass++;
        mem[0] = 8'h10;
        redirect_to(64'h0);
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h1, 3'd1))
            $display("FAIL adr_restart got=%h", observe());
        else n_pass++;
    endtask

    task automatic test_ins_hlt();
        clear_mem();
        mem[0] = 8'hC5;
        mem[8'h10] = 8'h00;
        do_reset();
        bus.f_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'hC, 4'h5, 4'hF, 4'hF, 64'h0, 64'h1, 64'h1, 3'd4))
            $display("FAIL ins_fields got=%h", observe());
        else n_pass++;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({bus.f_valid, bus.imem_addr} !== {1'b0, 64'h1})
            $display("FAIL ins_stopped got=%b/%h want=0/1", bus.f_valid, bus.imem_addr);
        else n_pass++;
        redirect_to(64'h10);
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h11, 64'h11, 3'd2))
            $display("FAIL hlt_fields got=%h", observe());
        else n_pass++;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({bus.f_valid, bus.imem_addr} !== {1'b0, 64'h11})
            $display("FAIL hlt_stopped got=%b/%h want=0/11", bus.f_valid, bus.imem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_priority();
        clear_mem();
        mem[0] = 8'h10;
        mem[8'h30] = 8'h20;
        mem[8'h31] = 8'h45;
        mem[8'h32] = 8'h10;
        mem[8'h50] = 8'h90;
        do_reset();
        bus.f_ready = 1'b1;
        redirect_to(64'h30);
        n_checks++;
        if ({bus.f_valid, bus.imem_addr} !== {1'b0, 64'h30})
            $display("FAIL redir_idle got=%b/%h want=0/30", bus.f_valid, bus.imem_addr);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h2, 4'h0, 4'h4, 4'h5, 64'h0, 64'h32, 64'h32, 3'd1))
            $display("FAIL redir_rrmovq got=%h", observe());
        else n_pass++;
        redirect_to(64'h50);
        n_checks++;
        if ({bus.f_valid, bus.imem_addr} !== {1'b0, 64'h50})
            $display("FAIL redir_beats_capture got=%b/%h want=0/50", bus.f_valid, bus.imem_addr);
        else n_pass++;
        bus.f_ready = 1'b0;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h51, 64'h51, 3'd1))
            $display("FAIL redir_ret got=%h", observe());
        else n_pass++;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({observe(), bus.imem_addr} !== {RST_OBS, 64'h0})
            $display("FAIL reset_mid_wait got=%h/%h want=%h/0", observe(), bus.imem_addr, RST_OBS);
        else n_pass++;
        @(negedge clock);
        reset = 1'b0;
        bus.f_ready = 1'b1;
        @(negedge clock);
        n_checks++;
        if (observe() !== mk(4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h1, 3'd1))
            $display("FAIL reset_restart got=%h", observe());
        else n_pass++;
    endtask

    task automatic build_program();
        logic [3:0] pick [10] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA, 4'hB};
        logic [7:0] term [4] = '{8'h00, 8'h90, 8'hC0, 8'hE3};
        logic [3:0] ic;
        logic [63:0] tgt;
        int addr;
        int n;
        for (int a = 0; a < IMEM; a++) mem[a] = 8'($urandom);
        addr = 0;
        n = int'($urandom_range(4, 14));
        for (int k = 0; k < n && addr <= 118; k++) begin
            ic = pick[$urandom_range(0, 9)];
            mem[addr] = {ic, 4'($urandom)};
            if ((ic == 4'h7 || ic == 4'h8) && ($urandom % 4 != 0)) begin
                tgt = 64'($urandom_range(0, 110));
                for (int j = 0; j < 8; j++) mem[addr + 1 + j] = tgt[8*j +: 8];
            end
            addr += LEN_TAB[ic];
        end
        if (addr < IMEM) mem[addr] = term[$urandom_range(0, 3)];
    endtask

    task automatic test_random();
        obs_t q [$];
        obs_t e;
        obs_t got;
        logic [63:0] pc;
        bit done;
        int cycles;
        for (int r = 0; r < 8; r++) begin
            build_program();
            q.delete();
            pc = 64'h0;
            done = 1'b0;
            for (int k = 0; k < 24 && !done; k++) begin
                e = ref_decode(pc);
                q.push_back(e);
                if (e.stat != 3'd1 || e.icode == 4'h9) done = 1'b1;
                pc = e.predpc;
            end
            do_reset();
            cycles = 0;
            while (q.size() > 0 && cycles < 600) begin
                bus.f_ready = ($urandom % 3) != 0;
                if (bus.f_valid && bus.f_ready) begin
                    e = q.pop_front();
                    got = observe();
                    n_checks++;
                    if (got !== e) $display("FAIL rand%0d_instr got=%h want=%h", r, got, e);
                    else n_pass++;
                end
                @(negedge clock);
                cycles++;
            end
            n_checks++;
            if (q.size() != 0) $display("FAIL rand%0d_timeout got=%0d pending want=0", r, q.size());
            else n_pass++;
            if (done) begin
                bus.f_ready = 1'b1;
                repeat (4) @(negedge clock);
                n_checks++;
                if (bus.f_valid !== 1'b0) $display("FAIL rand%0d_quiet got=%b want=0", r, bus.f_valid);
                else n_pass++;
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        test_reset();
        test_irmovq();
        test_jump_stall();
        test_ret();
        test_adr();
        test_ins_hlt();
        test_redirect_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
